// File: rtl/add_round_key.sv
// AES AddRoundKey stage with a 2-entry registered output FIFO.
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both 1; valid never waits for ready, and ready never depends
// combinationally on the other side's valid or ready.
module add_round_key #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] state_in,
    input  logic [WIDTH-1:0] round_key,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] state_out
);

    localparam logic [1:0] COUNT_FULL = 2'd2;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             in_ready_q, in_ready_d;
    logic             push, pop;
    logic [WIDTH-1:0] result;

    // The XOR is computed at the input and stored, so outputs come only from registers.
    assign result    = state_in ^ round_key;
    assign push      = in_valid && in_ready_q;
    assign pop       = (count_q != 2'd0) && out_ready;
    assign in_ready  = in_ready_q;
    assign out_valid = (count_q != 2'd0);
    assign state_out = out_valid ? mem_q[rd_ptr_q] : '0;

    // Next-state for pointers, occupancy and the registered ready flag.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        in_ready_d = in_ready_q;
        if (push) begin
            wr_ptr_d = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
        // Ready is registered from the next count, so it reflects the
        // occupancy that the coming cycle will actually see.
        in_ready_d = (count_d != COUNT_FULL);
    end

    // Control registers; reset empties the FIFO and holds off input until release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            in_ready_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            in_ready_q <= in_ready_d;
        end
    end

    // Storage; a full FIFO never has push asserted, so stored data stays put.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= result;
        end
    end

endmodule

// File: tb/tb_add_round_key.sv
// Directed bench for add_round_key with hand-computed vectors.
module tb_add_round_key;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] state_in;
    logic [127:0] round_key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] state_out;

    int errors = 0;
    int checks = 0;
    logic [127:0] exp_q [$];

    localparam logic [127:0] V_STATE = 128'h046681E5E0CB199A48F8D37A2806264C;
    localparam logic [127:0] V_KEY   = 128'hD4BF5D30E0B452AEB84111F11E2798E5;
    localparam logic [127:0] V_RES   = 128'hD0D9DCD5007F4B34F0B9C28B3621BEA9;

    add_round_key #(.WIDTH(128), .DEPTH(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .state_in  (state_in),
        .round_key (round_key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .state_out (state_out)
    );

    // Clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [127:0] s, input logic [127:0] k);
        in_valid  = v;
        state_in  = s;
        round_key = k;
    endtask

    initial begin
        logic [127:0] s, k, ra, rb;
        rst_n     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, '0, '0);

        // Reset state before any clock edge
        #2;
        check("rst_out_valid", {127'b0, out_valid}, 128'd0);
        check("rst_in_ready",  {127'b0, in_ready},  128'd0);
        check("rst_state_out", state_out, 128'd0);
        step();
        step();
        #2 rst_n = 1'b1;
        step();
        check("release_in_ready", {127'b0, in_ready}, 128'd1);
        check("release_out_valid", {127'b0, out_valid}, 128'd0);

        // Reference vector, one-cycle latency
        out_ready = 1'b1;
        drive(1'b1, V_STATE, V_KEY);
        step();
        drive(1'b0, '0, '0);
        check("vec_out_valid", {127'b0, out_valid}, 128'd1);
        check("vec_state_out", state_out, V_RES);
        step();
        check("vec_drained", {127'b0, out_valid}, 128'd0);

        // Identity, involution, all-ones
        drive(1'b1, V_STATE, 128'd0);
        step();
        check("identity", state_out, V_STATE);
        drive(1'b1, V_RES, V_KEY);
        step();
        check("involution", state_out, V_STATE);
        drive(1'b1, {128{1'b1}}, {16{8'h0F}});
        step();
        check("all_ones", state_out, {16{8'hF0}});
        drive(1'b0, '0, '0);
        step();
        check("all_ones_drained", {127'b0, out_valid}, 128'd0);

        // Backpressure: three pushes, only two accepted
        out_ready = 1'b0;
        drive(1'b1, 128'h11111111222222223333333344444444, 128'h0F0F0F0F0F0F0F0F0F0F0F0F0F0F0F0F);
        ra = 128'h1E1E1E1E2D2D2D2D3C3C3C3C4B4B4B4B;
        step();
        check("bp_in_ready_1", {127'b0, in_ready}, 128'd1);
        drive(1'b1, 128'hAAAAAAAAAAAAAAAAAAAAAAAAAAAAAAAA, 128'hFFFFFFFF00000000FFFFFFFF00000000);
        rb = 128'h55555555AAAAAAAA55555555AAAAAAAA;
        step();
        check("bp_full_in_ready", {127'b0, in_ready}, 128'd0);
        check("bp_head", state_out, ra);
        drive(1'b1, 128'hDEADBEEFDEADBEEFDEADBEEFDEADBEEF, 128'd0);
        step();
        check("bp_ignored_in_ready", {127'b0, in_ready}, 128'd0);
        check("bp_stable_1", state_out, ra);
        step();
        check("bp_stable_2", state_out, ra);
        drive(1'b0, '0, '0);
        out_ready = 1'b1;
        step();
        check("bp_second_valid", {127'b0, out_valid}, 128'd1);
        check("bp_second", state_out, rb);
        check("bp_in_ready_back", {127'b0, in_ready}, 128'd1);
        step();
        check("bp_empty", {127'b0, out_valid}, 128'd0);

        // Streaming: one transfer per cycle, checked through the expected queue
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            s = {$urandom, $urandom, $urandom, $urandom};
            k = {$urandom, $urandom, $urandom, $urandom};
            drive(1'b1, s, k);
            if (in_ready) exp_q.push_back(s ^ k);
            step();
            check("stream_valid", {127'b0, out_valid}, 128'd1);
            check("stream_in_ready", {127'b0, in_ready}, 128'd1);
            if (exp_q.size() != 0) check("stream_data", state_out, exp_q.pop_front());
            else check("stream_queue_empty", 128'd1, 128'd0);
        end
        drive(1'b0, '0, '0);
        step();
        check("stream_done", {127'b0, out_valid}, 128'd0);

        // Asynchronous reset with two entries buffered
        out_ready = 1'b0;
        drive(1'b1, V_STATE, V_KEY);
        step();
        drive(1'b1, V_RES, V_KEY);
        step();
        drive(1'b0, '0, '0);
        check("ar_full_before", {127'b0, in_ready}, 128'd0);
        #1 rst_n = 1'b0;
        #1;
        check("ar_out_valid", {127'b0, out_valid}, 128'd0);
        check("ar_in_ready", {127'b0, in_ready}, 128'd0);
        check("ar_state_out", state_out, 128'd0);
        step();
        #2 rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        check("ar_release_ready", {127'b0, in_ready}, 128'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("ar_no_stale", {127'b0, out_valid}, 128'd0);
        end
        drive(1'b1, {16{8'h5A}}, {16{8'hA5}});
        step();
        drive(1'b0, '0, '0);
        check("ar_new_valid", {127'b0, out_valid}, 128'd1);
        check("ar_new_data", state_out, {128{1'b1}});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/add_round_key.md
ADD_ROUND_KEY -- requirements
Module: add_round_key

Parameters
REQ-001 The block SHALL have parameter WIDTH, default 128, meaning the state/key width in bits; only 128 is supported.
REQ-002 The block SHALL have parameter DEPTH, default 2, meaning the output buffer entry count; only 2 is supported.

Interface
REQ-003 The block SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: state_in and round_key are valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: block can accept an input.
REQ-007 The block SHALL have port state_in, input, 128 bits: AES state, byte 0 at bits 127:120.
REQ-008 The block SHALL have port round_key, input, 128 bits: round key, same byte order as state_in.
REQ-009 The block SHALL have port out_valid, output, 1 bit: state_out is valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: downstream accepts state_out.
REQ-011 The block SHALL have port state_out, output, 128 bits: result of the round-key addition.

Function
REQ-012 An input transfer SHALL occur on a rising clk edge where in_valid and in_ready are both 1.
REQ-013 An output transfer SHALL occur on a rising clk edge where out_valid and out_ready are both 1.
REQ-014 Each accepted input SHALL produce result = state_in XOR round_key, bitwise across all 128 bits, with no carries and no byte reordering.
REQ-015 Results SHALL be stored in a 2-entry FIFO and presented in acceptance order.
REQ-016 state_out SHALL carry the oldest stored result whenever out_valid is 1.
REQ-017 Latency SHALL be 1 cycle: a result accepted at edge N SHALL show out_valid = 1 after edge N when the FIFO was empty.
REQ-018 There SHALL be no combinational path from in_valid or state_in to out_valid or state_out.
REQ-019 in_ready SHALL be 0 only when the FIFO holds 2 entries, and SHALL be driven from a register, with no combinational dependence on out_ready.
REQ-020 When 1 entry is held, a push and a pop on the same edge SHALL occur together, leave the count at 1, sustain 1 transfer per cycle, and lose no data.
REQ-021 When the FIFO is full, in_valid SHALL be ignored and the stored data SHALL be unchanged.
REQ-022 When the FIFO is empty, out_ready SHALL have no effect and out_valid SHALL be 0.
REQ-023 While out_valid = 1 and out_ready = 0, state_out SHALL hold stable.
REQ-024 Storage pointers SHALL wrap modulo 2.
REQ-025 Passing a value twice with the same key SHALL return the original value (XOR involution).

Reset
REQ-026 When rst_n = 0, the block SHALL immediately, without waiting for clk, force out_valid = 0, in_ready = 0, FIFO count = 0, both pointers = 0, and state_out = 0.
REQ-027 On the first rising clk edge after rst_n returns to 1, in_ready SHALL become 1.
REQ-028 Reset asserted mid-operation SHALL discard all buffered results, and no stale result SHALL appear after release.

Verification
REQ-029 Vector test: state_in = 046681E5E0CB199A48F8D37A2806264C, round_key = D4BF5D30E0B452AEB84111F11E2798E5, out_ready = 1 -> one cycle later out_valid = 1 and state_out = D0D9DCD5007F4B34F0B9C28B3621BEA9.
REQ-030 Identity and involution: key = 0 -> state_out = state_in; feeding result D0D9...BEA9 back with key D4BF...98E5 -> 046681E5E0CB199A48F8D37A2806264C.
REQ-031 Backpressure: out_ready = 0, push 3 distinct vectors -> first 2 accepted, in_ready = 0, state_out stable; raise out_ready -> both results emerge in order, then in_ready = 1.
REQ-032 Streaming: in_valid = 1 and out_ready = 1 every cycle for 16 vectors of random state and key -> 16 outputs on consecutive cycles, each equal to its state XOR key.
REQ-033 Async reset: assert rst_n = 0 between clock edges with 2 entries buffered -> out_valid = 0 immediately; after release, no outputs until new input.
REQ-034 All-ones: state_in = FF..FF, round_key = 0F0F..0F -> state_out = F0F0..F0.
